// File: rtl/cpu_dma_if.sv
// cpu_dma_if: shared CPU bus as seen by the DMA engine.
//   master modport (DMA): drives A, D, R, W, busy; receives I.
//   slave modport (memory / bus mux): the reverse.
//   A    : 16-bit bus address
//   I    : memory read data, valid the cycle after A is presented
//   D    : write data
//   R/W  : read / write strobes
//   busy : DMA owns the bus; the top level muxes A/D/R/W from the DMA when 1
interface cpu_dma_if;
  logic [15:0] A;
  logic [7:0]  I;
  logic [7:0]  D;
  logic        R;
  logic        W;
  logic        busy;

  modport master (output A, D, R, W, busy, input I);
  modport slave  (input A, D, R, W, busy, output I);
endinterface

// File: rtl/cpu_dma.sv
// cpu_dma: multi-channel bus-master DMA beside the 6502 core.
// Channel 0 copies a source page to the fixed register DST0 (OAM-style);
// channels 1..CHANNELS-1 copy a source page to a destination page.
// Triggers are snooped from CPU writes; the CPU is stalled by gating its ce.
//
// Ports:
//   clock, reset_n  : clock, synchronous active-low reset
//   ce              : bus cycle enable; nothing advances when ce=0
//   cpu_m0          : CPU opcode-load cycle (safe point to take the bus)
//   cpu_A/Do/W      : snooped CPU address, write data, write strobe
//   cpu_ce          : ce & ~stall, to the CPU core
//   bus             : DMA bus master (A, I, D, R, W, busy)
//   done            : one-ce-cycle completion pulse per channel
//   irq             : completion interrupt for channels >= 1
//
// Build option: define DMA_IRQ_EN to enable irq (set on completion of any
// channel >= 1, cleared by a CPU write to EXT_BASE+15). Undefined: irq=0.
//
// state | meaning
// IDLE  | waiting for a pending channel and an instruction boundary
// HALT  | first stalled cycle, bus quiet
// ALIGN | extra dummy cycle when the halt landed on odd parity
// RD    | read strobe, A = {src, cnt}
// WR    | write strobe, D = I, A = DST0 or {dpg, cnt}
// DONE  | completion pulse; CPU already released
module cpu_dma #(
  parameter int          CHANNELS  = 2,
  parameter int          LEN       = 256,
  parameter logic [15:0] TRIG_BASE = 16'h4014,
  parameter logic [15:0] DST0      = 16'h2004,
  parameter logic [15:0] EXT_BASE  = 16'h5000
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                ce,
  input  logic                cpu_m0,
  input  logic [15:0]         cpu_A,
  input  logic [7:0]          cpu_Do,
  input  logic                cpu_W,
  output logic                cpu_ce,
  cpu_dma_if.master           bus,
  output logic [CHANNELS-1:0] done,
  output logic                irq
);

  localparam int CW  = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_HALT, S_ALIGN, S_RD, S_WR, S_DONE
  } state_t;

  state_t                     state_q, state_d;
  logic [CHW-1:0]             ch_q, ch_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [CHANNELS-1:0]        pend_q, pend_d;
  logic [CHANNELS-1:0][7:0]   src_q, src_d;
  logic [CHANNELS-1:0][7:0]   dpg_q, dpg_d;
  logic                       parity_q, parity_d;
  logic                       stall_q, stall_d;
  logic                       busy_q, busy_d;
  logic                       r_q, r_d;
  logic                       w_q, w_d;
  logic [15:0]                a_q, a_d;
  logic [CHANNELS-1:0]        done_q, done_d;

  logic [CHW-1:0] sel;
  logic           sel_vld;
  logic [CW-1:0]  cnt_inc;
  logic           last;
  logic [15:0]    rd_addr;
  logic [15:0]    wr_addr;
  logic [15:0]    rd_addr_next;

  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (pend_q[k]) begin
        sel     = CHW'(k);
        sel_vld = 1'b1;
      end
    end
  end

  // Byte addressing stays inside the page: the count never carries into the page byte.
  assign cnt_inc      = cnt_q + CW'(1);
  assign last         = (cnt_q == CW'(LEN - 1));
  assign rd_addr      = {src_q[ch_q], 8'(cnt_q)};
  assign rd_addr_next = {src_q[ch_q], 8'(cnt_inc)};
  assign wr_addr      = (ch_q == '0) ? DST0 : {dpg_q[ch_q], 8'(cnt_q)};

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    src_d    = src_q;
    dpg_d    = dpg_q;
    parity_d = parity_q;
    stall_d  = stall_q;
    busy_d   = busy_q;
    r_d      = r_q;
    w_d      = w_q;
    a_d      = a_q;
    done_d   = done_q;

    if (ce) begin
      parity_d = ~parity_q;
      done_d   = '0;

      case (state_q)
        S_IDLE: begin
          if (sel_vld && cpu_m0) begin
            ch_d         = sel;
            pend_d[sel]  = 1'b0;
            stall_d      = 1'b1;
            busy_d       = 1'b1;
            state_d      = S_HALT;
          end
        end
        S_HALT: begin
          if (parity_q) begin
            state_d = S_ALIGN;
          end else begin
            state_d = S_RD;
            r_d     = 1'b1;
            a_d     = rd_addr;
          end
        end
        S_ALIGN: begin
          state_d = S_RD;
          r_d     = 1'b1;
          a_d     = rd_addr;
        end
        S_RD: begin
          state_d = S_WR;
          r_d     = 1'b0;
          w_d     = 1'b1;
          a_d     = wr_addr;
        end
        S_WR: begin
          w_d = 1'b0;
          if (last) begin
            // Stall drops as DONE is entered so the CPU runs during DONE itself.
            state_d      = S_DONE;
            cnt_d        = '0;
            done_d[ch_q] = 1'b1;
            stall_d      = 1'b0;
            busy_d       = 1'b0;
            a_d          = '0;
          end else begin
            state_d = S_RD;
            cnt_d   = cnt_inc;
            r_d     = 1'b1;
            a_d     = rd_addr_next;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase

      // Snoop after the FSM so a re-trigger in the selection cycle stays pending.
      if (cpu_W) begin
        if (cpu_A == TRIG_BASE) begin
          src_d[0]  = cpu_Do;
          pend_d[0] = 1'b1;
        end
        for (int k = 1; k < CHANNELS; k++) begin
          if (cpu_A == EXT_BASE + 16'(2 * (k - 1))) begin
            dpg_d[k] = cpu_Do;
          end
          if (cpu_A == EXT_BASE + 16'(2 * (k - 1) + 1)) begin
            src_d[k]  = cpu_Do;
            pend_d[k] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      ch_q     <= '0;
      cnt_q    <= '0;
      pend_q   <= '0;
      src_q    <= '0;
      dpg_q    <= '0;
      parity_q <= 1'b0;
      stall_q  <= 1'b0;
      busy_q   <= 1'b0;
      r_q      <= 1'b0;
      w_q      <= 1'b0;
      a_q      <= '0;
      done_q   <= '0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      src_q    <= src_d;
      dpg_q    <= dpg_d;
      parity_q <= parity_d;
      stall_q  <= stall_d;
      busy_q   <= busy_d;
      r_q      <= r_d;
      w_q      <= w_d;
      a_q      <= a_d;
      done_q   <= done_d;
    end
  end

`ifdef DMA_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = irq_q;
    if (ce) begin
      if (cpu_W && (cpu_A == EXT_BASE + 16'd15)) begin
        irq_d = 1'b0;
      end
      // Set is evaluated last so it wins over a same-cycle clear.
      if ((state_q == S_WR) && last && (ch_q != '0)) begin
        irq_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  assign cpu_ce   = ce & ~stall_q;
  assign done     = done_q;
  assign bus.A    = a_q;
  assign bus.R    = r_q;
  assign bus.W    = w_q;
  assign bus.busy = busy_q;
  // The byte read in RD arrives on I during WR and is forwarded unregistered.
  assign bus.D    = w_q ? bus.I : 8'h00;

endmodule

// File: tb/tb_cpu_dma.sv
module tb_cpu_dma;
  logic        clock;
  logic        reset_n;
  logic        ce;
  logic        cpu_m0;
  logic [15:0] cpu_A;
  logic [7:0]  cpu_Do;
  logic        cpu_W;
  logic        cpu_ce;
  logic [1:0]  done;
  logic        irq;

  cpu_dma_if bus_if ();

  cpu_dma dut (
    .clock   (clock),
    .reset_n (reset_n),
    .ce      (ce),
    .cpu_m0  (cpu_m0),
    .cpu_A   (cpu_A),
    .cpu_Do  (cpu_Do),
    .cpu_W   (cpu_W),
    .cpu_ce  (cpu_ce),
    .bus     (bus_if),
    .done    (done),
    .irq     (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int oam_n = 0;
  int p60_n = 0;
  int stall_n = 0;
  int d0_n = 0;
  int d1_n = 0;
  int r_n = 0;
  int w_n = 0;
  logic [7:0] oam_log [0:2047];
  logic [7:0] dst_mem [0:255];

  // Source pages: $02xx holds i^$5A, $03xx holds 3*i+1.
  function automatic logic [7:0] rd_fn(input logic [15:0] a);
    if (a[15:8] == 8'h02) return a[7:0] ^ 8'h5A;
    if (a[15:8] == 8'h03) return 8'(a[7:0] * 3 + 1);
    return a[15:8] ^ a[7:0];
  endfunction

  always @(posedge clock) begin
    if (!reset_n) cyc <= 0;
    else if (ce) cyc <= cyc + 1;
    if (ce) begin
      if (bus_if.R) begin
        bus_if.I <= rd_fn(bus_if.A);
        r_n <= r_n + 1;
      end
      if (bus_if.W) begin
        w_n <= w_n + 1;
        if (bus_if.A == 16'h2004) begin
          if (oam_n < 2048) oam_log[oam_n] <= bus_if.D;
          oam_n <= oam_n + 1;
        end else if (bus_if.A[15:8] == 8'h60) begin
          dst_mem[bus_if.A[7:0]] <= bus_if.D;
          p60_n <= p60_n + 1;
        end
      end
      if (!cpu_ce) stall_n <= stall_n + 1;
      if (done[0]) d0_n <= d0_n + 1;
      if (done[1]) d1_n <= d1_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
    cpu_A = a; cpu_Do = d; cpu_W = 1'b1;
    @(negedge clock);
    cpu_W = 1'b0; cpu_A = 16'h0000; cpu_Do = 8'h00;
  endtask

  task automatic m0_pulse();
    cpu_m0 = 1'b1;
    @(negedge clock);
    cpu_m0 = 1'b0;
  endtask

  task automatic wait_done(input int which, input int base, input int budget, input string tag);
    int n = 0;
    while (((which == 0) ? d0_n : d1_n) <= base && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk(tag, 32'(n >= budget), 32'd0);
  endtask

  task automatic check_oam(input int base, input string tag);
    int bad = 0;
    for (int i = 0; i < 256; i++)
      if (oam_log[base + i] !== (8'(i) ^ 8'h5A)) bad++;
    chk(tag, 32'(bad), 32'd0);
  endtask

  int b_oam, b_st, b_d0, b_d1, b_p60, b_r, b_w, n, bad;
  logic [25:0] held;

  initial begin
    reset_n = 1'b0; ce = 1'b1; cpu_m0 = 1'b0; cpu_A = '0; cpu_Do = '0; cpu_W = 1'b0;
    bus_if.I = 8'h00;
    repeat (3) @(negedge clock);
    chk("rst_busy", 32'(bus_if.busy), 32'd0);
    chk("rst_rw", 32'({bus_if.R, bus_if.W}), 32'd0);
    chk("rst_a_d", 32'({bus_if.A, bus_if.D}), 32'd0);
    chk("rst_done_irq", 32'({done, irq}), 32'd0);
    chk("rst_cpu_ce", 32'(cpu_ce), 32'd1);
    reset_n = 1'b1; ce = 1'b0;
    @(negedge clock);
    chk("cpu_ce_gated_by_ce", 32'(cpu_ce), 32'd0);
    ce = 1'b1;
    @(negedge clock);

    // 1: even-parity trigger of channel 0
    if (cyc[0]) @(negedge clock);
    b_oam = oam_n; b_st = stall_n; b_d0 = d0_n;
    cpu_wr(16'h4014, 8'h02);
    m0_pulse();
    chk("s1_busy_start", 32'(bus_if.busy), 32'd1);
    wait_done(0, b_d0, 1200, "s1_timeout");
    repeat (3) @(negedge clock);
    chk("s1_stall", 32'(stall_n - b_st), 32'd513);
    chk("s1_bytes", 32'(oam_n - b_oam), 32'd256);
    check_oam(b_oam, "s1_data");
    chk("s1_done0", 32'(d0_n - b_d0), 32'd1);

    // 2: odd-parity trigger
    if (!cyc[0]) @(negedge clock);
    b_oam = oam_n; b_st = stall_n; b_d0 = d0_n;
    cpu_wr(16'h4014, 8'h02);
    m0_pulse();
    wait_done(0, b_d0, 1200, "s2_timeout");
    repeat (3) @(negedge clock);
    chk("s2_stall", 32'(stall_n - b_st), 32'd514);
    chk("s2_bytes", 32'(oam_n - b_oam), 32'd256);
    check_oam(b_oam, "s2_data");

    // 3: channel 1 page copy $03xx -> $60xx
    b_p60 = p60_n; b_d1 = d1_n;
    cpu_wr(16'h5000, 8'h60);
    cpu_wr(16'h5001, 8'h03);
    m0_pulse();
    wait_done(1, b_d1, 1200, "s3_timeout");
    chk("s3_writes", 32'(p60_n - b_p60), 32'd256);
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (dst_mem[i] !== 8'(i * 3 + 1)) bad++;
    chk("s3_data", 32'(bad), 32'd0);
    chk("s3_done1", 32'(d1_n - b_d1), 32'd1);
`ifdef DMA_IRQ_EN
    chk("s3_irq_set", 32'(irq), 32'd1);
    cpu_wr(16'h500F, 8'h00);
    chk("s3_irq_clr", 32'(irq), 32'd0);
`else
    chk("s3_irq_off", 32'(irq), 32'd0);
`endif

    // 4: ch1 triggered while ch0 runs; ch1 waits for the next m0
    b_oam = oam_n; b_p60 = p60_n; b_d0 = d0_n; b_d1 = d1_n;
    cpu_wr(16'h4014, 8'h02);
    m0_pulse();
    repeat (10) @(negedge clock);
    cpu_wr(16'h5001, 8'h03);
    wait_done(0, b_d0, 1200, "s4_ch0_timeout");
    chk("s4_no_chain", 32'(d1_n - b_d1), 32'd0);
    repeat (4) @(negedge clock);
    chk("s4_idle_busy", 32'(bus_if.busy), 32'd0);
    chk("s4_cpu_runs", 32'(cpu_ce), 32'd1);
    m0_pulse();
    chk("s4_ch1_start", 32'(bus_if.busy), 32'd1);
    wait_done(1, b_d1, 1200, "s4_ch1_timeout");
    chk("s4_ch0_bytes", 32'(oam_n - b_oam), 32'd256);
    chk("s4_ch1_bytes", 32'(p60_n - b_p60), 32'd256);

    // 5: ce=0 inside RD and inside WR
    b_oam = oam_n; b_d0 = d0_n;
    cpu_wr(16'h4014, 8'h02);
    m0_pulse();
    n = 0;
    while (!bus_if.R && n < 10) begin
      @(negedge clock);
      n++;
    end
    chk("s5_rd_seen", 32'(bus_if.R), 32'd1);
    ce = 1'b0;
    held = {bus_if.A, bus_if.D, bus_if.R, bus_if.W};
    b_r = r_n;
    repeat (5) begin
      @(negedge clock);
      chk("s5_rd_hold", 32'({bus_if.A, bus_if.D, bus_if.R, bus_if.W}), 32'(held));
    end
    chk("s5_rd_no_strobe", 32'(r_n - b_r), 32'd0);
    ce = 1'b1;
    @(negedge clock);
    chk("s5_wr_state", 32'(bus_if.W), 32'd1);
    ce = 1'b0;
    held = {bus_if.A, bus_if.D, bus_if.R, bus_if.W};
    b_w = w_n;
    repeat (5) begin
      @(negedge clock);
      chk("s5_wr_hold", 32'({bus_if.A, bus_if.D, bus_if.R, bus_if.W}), 32'(held));
    end
    chk("s5_wr_no_strobe", 32'(w_n - b_w), 32'd0);
    ce = 1'b1;
    wait_done(0, b_d0, 1200, "s5_timeout");
    chk("s5_bytes", 32'(oam_n - b_oam), 32'd256);
    check_oam(b_oam, "s5_data");

    // 6: reset after 100 bytes
    b_oam = oam_n;
    cpu_wr(16'h4014, 8'h02);
    m0_pulse();
    n = 0;
    while ((oam_n - b_oam) < 100 && n < 400) begin
      @(negedge clock);
      n++;
    end
    chk("s6_reach_100", 32'(oam_n - b_oam), 32'd100);
    reset_n = 1'b0;
    @(negedge clock);
    chk("s6_busy", 32'(bus_if.busy), 32'd0);
    chk("s6_rw", 32'({bus_if.R, bus_if.W}), 32'd0);
    chk("s6_cpu_ce", 32'(cpu_ce), 32'd1);
    ce = 1'b0;
    @(negedge clock);
    chk("s6_cpu_ce_ce0", 32'(cpu_ce), 32'd0);
    ce = 1'b1;
    reset_n = 1'b1;
    repeat (20) @(negedge clock);
    chk("s6_no_more_writes", 32'(oam_n - b_oam), 32'd100);
    chk("s6_idle", 32'(bus_if.busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
